// File: rtl/cricket_match_ctrl.sv
// ---------------------------------------------------------------------------
// cricket_match_ctrl
// Two-innings limited-overs cricket match controller. Every rising edge of
// ball_sw scores one delivery whose outcome code comes either from a
// free-running Fibonacci LFSR or from force_code. The block counts runs,
// wickets, overs and balls, sets the chase target at the innings break and
// declares the winner (or a tie) when the second innings finishes.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-low reset
//   ball_sw      bowl switch, one delivery per rising edge
//   team_switch  rising edge during the innings break starts innings 2
//   force_en     1 = take the outcome from force_code instead of the LFSR
//   force_code   forced outcome code
//   inning_over  high in the innings break and after the match ends
//   game_over    high once the match has ended
//   winner       0 = team batting first, 1 = chasing team (valid at game_over)
//   tie          scores level at the end of the match
//   innings      0 = first innings, 1 = second innings
//   lfsr_out     current LFSR state
//   last_code    outcome code of the most recent scored delivery
//   ball_valid   one-cycle pulse for each scored delivery
//   runs         runs in the current innings (saturating)
//   wickets      wickets in the current innings
//   over_cnt     completed overs
//   ball_cnt     legal balls bowled in the current over
//   target       first-innings runs + 1, zero during the first innings
// Outcome codes: 0 dot, 1..4 runs, 5 six, 6 wicket, 7 wide (+1, not a ball).
// ---------------------------------------------------------------------------
module cricket_match_ctrl #(
    parameter int unsigned         BALLS_PER_OVER = 32'd6,
    parameter int unsigned         OVERS          = 32'd20,
    parameter int unsigned         MAX_WICKETS    = 32'd10,
    parameter int unsigned         RUN_W          = 32'd10,
    parameter int unsigned         LFSR_W         = 32'd4,
    parameter logic [LFSR_W-1:0]   LFSR_TAPS      = 4'b1100,
    parameter logic [LFSR_W-1:0]   LFSR_SEED      = 4'b1001
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               ball_sw,
    input  logic                               team_switch,
    input  logic                               force_en,
    input  logic [2:0]                         force_code,
    output logic                               inning_over,
    output logic                               game_over,
    output logic                               winner,
    output logic                               tie,
    output logic                               innings,
    output logic [LFSR_W-1:0]                  lfsr_out,
    output logic [2:0]                         last_code,
    output logic                               ball_valid,
    output logic [RUN_W-1:0]                   runs,
    output logic [$clog2(MAX_WICKETS+1)-1:0]   wickets,
    output logic [$clog2(OVERS+1)-1:0]         over_cnt,
    output logic [$clog2(BALLS_PER_OVER)-1:0]  ball_cnt,
    output logic [RUN_W-1:0]                   target
);

    localparam int unsigned WK_W = $clog2(MAX_WICKETS + 32'd1);
    localparam int unsigned OV_W = $clog2(OVERS + 32'd1);
    localparam int unsigned BC_W = $clog2(BALLS_PER_OVER);

    typedef enum logic [1:0] {
        ST_INN1  = 2'd0,
        ST_BREAK = 2'd1,
        ST_INN2  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Even-parity reduction used as the LFSR feedback bit.
    function automatic logic parity(input logic [LFSR_W-1:0] v);
        return ^v;
    endfunction

    // One LFSR step; an all-zero state (lock-up) is recovered by reseeding.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] n;
        if (s == {LFSR_W{1'b0}}) begin
            n = LFSR_SEED;
        end else begin
            n = {s[LFSR_W-2:0], parity(s & LFSR_TAPS)};
        end
        return n;
    endfunction

    state_t             state_r;
    logic [LFSR_W-1:0]  lfsr_r;
    logic               ball_sw_q_r;
    logic               team_sw_q_r;
    logic               inning_over_r;
    logic               game_over_r;
    logic               winner_r;
    logic               tie_r;
    logic               innings_r;
    logic [2:0]         last_code_r;
    logic               ball_valid_r;
    logic [RUN_W-1:0]   runs_r;
    logic [WK_W-1:0]    wickets_r;
    logic [OV_W-1:0]    over_cnt_r;
    logic [BC_W-1:0]    ball_cnt_r;
    logic [RUN_W-1:0]   target_r;

    logic               ball_edge_s;
    logic               team_edge_s;
    logic [2:0]         code_s;
    logic [2:0]         add_s;
    logic [RUN_W:0]     sum_s;
    logic [RUN_W-1:0]   runs_next_s;
    logic [WK_W-1:0]    wk_next_s;
    logic [OV_W-1:0]    ov_next_s;
    logic [BC_W-1:0]    bc_next_s;
    logic               innings_end_s;
    logic               chase_won_s;
    logic               tie_s;

    assign ball_edge_s = ball_sw & ~ball_sw_q_r;
    assign team_edge_s = team_switch & ~team_sw_q_r;
    assign code_s      = force_en ? force_code : lfsr_r[2:0];

    // Outcome decode: runs added by the current delivery.
    always_comb begin
        add_s = 3'd0;
        case (code_s)
            3'd0:    add_s = 3'd0;
            3'd1:    add_s = 3'd1;
            3'd2:    add_s = 3'd2;
            3'd3:    add_s = 3'd3;
            3'd4:    add_s = 3'd4;
            3'd5:    add_s = 3'd6;
            3'd6:    add_s = 3'd0;
            3'd7:    add_s = 3'd1;
            default: add_s = 3'd0;
        endcase
    end

    // Post-delivery score values; sum is one bit wider to detect saturation.
    always_comb begin
        sum_s       = {1'b0, runs_r} + {{(RUN_W - 32'd2){1'b0}}, add_s};
        runs_next_s = runs_r;
        wk_next_s   = wickets_r;
        ov_next_s   = over_cnt_r;
        bc_next_s   = ball_cnt_r;

        if (sum_s[RUN_W]) begin
            runs_next_s = {RUN_W{1'b1}};
        end else begin
            runs_next_s = sum_s[RUN_W-1:0];
        end

        if (code_s == 3'd6) begin
            wk_next_s = wickets_r + {{(WK_W - 32'd1){1'b0}}, 1'b1};
        end else begin
            wk_next_s = wickets_r;
        end

        // Wides are not legal balls and leave the over untouched.
        if (code_s != 3'd7) begin
            if (ball_cnt_r == BC_W'(BALLS_PER_OVER - 32'd1)) begin
                bc_next_s = {BC_W{1'b0}};
                ov_next_s = over_cnt_r + {{(OV_W - 32'd1){1'b0}}, 1'b1};
            end else begin
                bc_next_s = ball_cnt_r + {{(BC_W - 32'd1){1'b0}}, 1'b1};
                ov_next_s = over_cnt_r;
            end
        end else begin
            bc_next_s = ball_cnt_r;
            ov_next_s = over_cnt_r;
        end
    end

    // Innings termination and result decisions on the post-delivery values.
    always_comb begin
        innings_end_s = (wk_next_s == WK_W'(MAX_WICKETS)) ||
                        (ov_next_s == OV_W'(OVERS));
        chase_won_s   = (runs_next_s >= target_r);
        // Compare one bit wider so runs = all-ones cannot wrap into a tie.
        tie_s         = (({1'b0, runs_next_s} + {{RUN_W{1'b0}}, 1'b1}) ==
                         {1'b0, target_r});
    end

    // Match state machine, LFSR, edge detectors and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_INN1;
            lfsr_r        <= LFSR_SEED;
            ball_sw_q_r   <= 1'b1;
            team_sw_q_r   <= 1'b1;
            inning_over_r <= 1'b0;
            game_over_r   <= 1'b0;
            winner_r      <= 1'b0;
            tie_r         <= 1'b0;
            innings_r     <= 1'b0;
            last_code_r   <= 3'd0;
            ball_valid_r  <= 1'b0;
            runs_r        <= {RUN_W{1'b0}};
            wickets_r     <= {WK_W{1'b0}};
            over_cnt_r    <= {OV_W{1'b0}};
            ball_cnt_r    <= {BC_W{1'b0}};
            target_r      <= {RUN_W{1'b0}};
        end else begin
            lfsr_r       <= lfsr_step(lfsr_r);
            ball_sw_q_r  <= ball_sw;
            team_sw_q_r  <= team_switch;
            ball_valid_r <= 1'b0;

            case (state_r)
                ST_INN1, ST_INN2: begin
                    if (ball_edge_s) begin
                        ball_valid_r <= 1'b1;
                        last_code_r  <= code_s;
                        runs_r       <= runs_next_s;
                        wickets_r    <= wk_next_s;
                        over_cnt_r   <= ov_next_s;
                        ball_cnt_r   <= bc_next_s;
                        if (state_r == ST_INN1) begin
                            if (innings_end_s) begin
                                state_r       <= ST_BREAK;
                                inning_over_r <= 1'b1;
                                target_r      <= runs_next_s + {{(RUN_W - 32'd1){1'b0}}, 1'b1};
                            end else begin
                                state_r <= ST_INN1;
                            end
                        end else begin
                            // A winning run takes priority over a coincident all-out.
                            if (chase_won_s) begin
                                state_r       <= ST_DONE;
                                inning_over_r <= 1'b1;
                                game_over_r   <= 1'b1;
                                winner_r      <= 1'b1;
                                tie_r         <= 1'b0;
                            end else if (innings_end_s) begin
                                state_r       <= ST_DONE;
                                inning_over_r <= 1'b1;
                                game_over_r   <= 1'b1;
                                winner_r      <= 1'b0;
                                tie_r         <= tie_s;
                            end else begin
                                state_r <= ST_INN2;
                            end
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_BREAK: begin
                    if (team_edge_s) begin
                        state_r       <= ST_INN2;
                        inning_over_r <= 1'b0;
                        innings_r     <= 1'b1;
                        runs_r        <= {RUN_W{1'b0}};
                        wickets_r     <= {WK_W{1'b0}};
                        over_cnt_r    <= {OV_W{1'b0}};
                        ball_cnt_r    <= {BC_W{1'b0}};
                        last_code_r   <= 3'd0;
                    end else begin
                        state_r <= ST_BREAK;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r <= ST_INN1;
                end
            endcase
        end
    end

    assign inning_over = inning_over_r;
    assign game_over   = game_over_r;
    assign winner      = winner_r;
    assign tie         = tie_r;
    assign innings     = innings_r;
    assign lfsr_out    = lfsr_r;
    assign last_code   = last_code_r;
    assign ball_valid  = ball_valid_r;
    assign runs        = runs_r;
    assign wickets     = wickets_r;
    assign over_cnt    = over_cnt_r;
    assign ball_cnt    = ball_cnt_r;
    assign target      = target_r;

endmodule

// File: tb/tb_cricket_match_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cricket_match_ctrl
// Directed bench for cricket_match_ctrl (6 balls/over, 2 overs, 3 wickets).
// A behavioural match model predicts each delivery; predictions are queued
// when a delivery is driven and checked when ball_valid appears.
// ---------------------------------------------------------------------------
module tb_cricket_match_ctrl;

    localparam int BPO = 6;
    localparam int OVS = 2;
    localparam int MW  = 3;
    localparam int RMAX = 1023;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ball_sw = 1'b0;
    logic        team_switch = 1'b0;
    logic        force_en = 1'b1;
    logic [2:0]  force_code = 3'd0;
    logic        inning_over, game_over, winner, tie, innings, ball_valid;
    logic [3:0]  lfsr_out;
    logic [2:0]  last_code;
    logic [9:0]  runs, target;
    logic [1:0]  wickets, over_cnt;
    logic [2:0]  ball_cnt;

    cricket_match_ctrl #(
        .BALLS_PER_OVER(BPO),
        .OVERS(OVS),
        .MAX_WICKETS(MW)
    ) dut (
        .clk(clk), .reset(reset), .ball_sw(ball_sw), .team_switch(team_switch),
        .force_en(force_en), .force_code(force_code),
        .inning_over(inning_over), .game_over(game_over), .winner(winner),
        .tie(tie), .innings(innings), .lfsr_out(lfsr_out), .last_code(last_code),
        .ball_valid(ball_valid), .runs(runs), .wickets(wickets),
        .over_cnt(over_cnt), .ball_cnt(ball_cnt), .target(target)
    );

    always #5 clk = ~clk;

    typedef struct {
        int code;
        int runs;
        int wk;
        int ov;
        int bc;
    } exp_t;

    exp_t sb_q[$];
    int total = 0;
    int bad   = 0;

    // Match model: 0 innings 1, 1 break, 2 innings 2, 3 done.
    int m_state, m_runs, m_wk, m_ov, m_bc, m_target, m_inn, m_win, m_tie, m_code;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] lfsr_ref(input logic [3:0] s);
        if (s == 4'd0) return 4'b1001;
        else return {s[2:0], s[3] ^ s[2]};
    endfunction

    task automatic model_reset();
        m_state = 0; m_runs = 0; m_wk = 0; m_ov = 0; m_bc = 0;
        m_target = 0; m_inn = 0; m_win = 0; m_tie = 0; m_code = 0;
    endtask

    task automatic model_ball(input int code);
        exp_t e;
        int add;
        add = (code == 5) ? 6 : (code == 6) ? 0 : (code == 7) ? 1 : code;
        m_runs = (m_runs + add > RMAX) ? RMAX : m_runs + add;
        m_code = code;
        if (code == 6) m_wk++;
        if (code != 7) begin
            m_bc++;
            if (m_bc == BPO) begin
                m_bc = 0;
                m_ov++;
            end
        end
        if (m_state == 0) begin
            if (m_wk == MW || m_ov == OVS) begin
                m_state = 1;
                m_target = m_runs + 1;
            end
        end else begin
            if (m_runs >= m_target) begin
                m_state = 3; m_win = 1; m_tie = 0;
            end else if (m_wk == MW || m_ov == OVS) begin
                m_state = 3; m_win = 0; m_tie = (m_runs == m_target - 1) ? 1 : 0;
            end
        end
        e.code = code; e.runs = m_runs; e.wk = m_wk; e.ov = m_ov; e.bc = m_bc;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_reset();
        sb_q.delete();
    endtask

    task automatic bowl(input logic [2:0] code);
        @(negedge clk);
        force_code = code;
        ball_sw = 1'b1;
        if (m_state == 0 || m_state == 2) model_ball(int'(code));
        @(negedge clk);
        ball_sw = 1'b0;
        @(negedge clk);
        chk("sb_drain", sb_q.size(), 0);
    endtask

    task automatic tswitch();
        @(negedge clk);
        team_switch = 1'b1;
        if (m_state == 1) begin
            m_state = 2; m_inn = 1;
            m_runs = 0; m_wk = 0; m_ov = 0; m_bc = 0; m_code = 0;
        end
        @(negedge clk);
        team_switch = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_all(input string p);
        chk({p, "_runs"},   runs,        m_runs);
        chk({p, "_wk"},     wickets,     m_wk);
        chk({p, "_ov"},     over_cnt,    m_ov);
        chk({p, "_bc"},     ball_cnt,    m_bc);
        chk({p, "_target"}, target,      m_target);
        chk({p, "_inn"},    innings,     m_inn);
        chk({p, "_iover"},  inning_over, (m_state == 1 || m_state == 3) ? 1 : 0);
        chk({p, "_gover"},  game_over,   (m_state == 3) ? 1 : 0);
        chk({p, "_winner"}, winner,      m_win);
        chk({p, "_tie"},    tie,         m_tie);
        chk({p, "_code"},   last_code,   m_code);
    endtask

    // Scoreboard monitor: every ball_valid pulse must match a queued prediction.
    always @(negedge clk) begin
        if (ball_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_code", last_code, e.code);
                chk("sb_runs", runs,      e.runs);
                chk("sb_wk",   wickets,   e.wk);
                chk("sb_ov",   over_cnt,  e.ov);
                chk("sb_bc",   ball_cnt,  e.bc);
            end
        end
    end

    initial begin
        logic [3:0] exp_lfsr;
        logic [15:0] seen;
        int nseen;

        model_reset();

        // 1. Reset values and LFSR sequence.
        do_reset();
        check_all("rst");
        chk("rst_lfsr", lfsr_out, 4'b1001);
        chk("rst_valid", ball_valid, 0);
        force_en = 1'b0;
        exp_lfsr = 4'b1001;
        seen = 16'd0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            exp_lfsr = lfsr_ref(exp_lfsr);
            chk("lfsr_step", lfsr_out, exp_lfsr);
            seen[lfsr_out] = 1'b1;
        end
        nseen = 0;
        for (int i = 1; i < 16; i++) if (seen[i]) nseen++;
        chk("lfsr_distinct", nseen, 15);
        chk("lfsr_zero_unseen", seen[0], 0);
        chk("lfsr_wrap", lfsr_out, 4'b1001);
        force_en = 1'b1;

        // 2. Scoring including a wide.
        do_reset();
        bowl(3'd4); chk("s1_runs", runs, 4);  chk("s1_bc", ball_cnt, 1);
        bowl(3'd5); chk("s2_runs", runs, 10); chk("s2_bc", ball_cnt, 2);
        bowl(3'd1); chk("s3_runs", runs, 11); chk("s3_bc", ball_cnt, 3);
        bowl(3'd7); chk("s4_runs", runs, 12); chk("s4_bc", ball_cnt, 3);
        chk("s4_code", last_code, 7);
        check_all("score");

        // 3. Overs complete the innings; deliveries in the break are ignored.
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            bowl(3'd0);
            if (i == 6) begin
                chk("ov6_ov", over_cnt, 1);
                chk("ov6_bc", ball_cnt, 0);
            end
        end
        chk("ov12_iover", inning_over, 1);
        chk("ov12_target", target, 1);
        bowl(3'd3);
        bowl(3'd5);
        check_all("brk_ignore");

        // 4. All out, then the innings break.
        do_reset();
        bowl(3'd6); bowl(3'd2); bowl(3'd6);
        chk("ao3_iover", inning_over, 0);
        bowl(3'd6);
        chk("ao_iover", inning_over, 1);
        chk("ao_wk", wickets, 3);
        chk("ao_runs", runs, 2);
        chk("ao_target", target, 3);
        tswitch();
        chk("inn2_inn", innings, 1);
        chk("inn2_runs", runs, 0);
        chk("inn2_iover", inning_over, 0);
        chk("inn2_target", target, 3);
        tswitch();
        check_all("ts_ignored");

        // 5a. Successful chase.
        do_reset();
        bowl(3'd5); bowl(3'd4); bowl(3'd6); bowl(3'd6); bowl(3'd6);
        chk("c_target", target, 11);
        tswitch();
        bowl(3'd5);
        chk("c1_gover", game_over, 0);
        bowl(3'd5);
        chk("c_gover", game_over, 1);
        chk("c_winner", winner, 1);
        chk("c_tie", tie, 0);
        chk("c_runs", runs, 12);
        bowl(3'd4);
        tswitch();
        check_all("done_frozen");

        // 5b. Tie: chasing side all out one short of the target.
        do_reset();
        bowl(3'd5); bowl(3'd4); bowl(3'd6); bowl(3'd6); bowl(3'd6);
        tswitch();
        bowl(3'd5); bowl(3'd4); bowl(3'd6); bowl(3'd6); bowl(3'd6);
        chk("t_gover", game_over, 1);
        chk("t_tie", tie, 1);
        chk("t_winner", winner, 0);
        chk("t_runs", runs, 10);
        check_all("tie");

        // 6. Reset abort in innings 2 with ball_sw held high.
        do_reset();
        bowl(3'd6); bowl(3'd6); bowl(3'd6);
        tswitch();
        bowl(3'd0);
        @(negedge clk);
        force_code = 3'd0;
        ball_sw = 1'b1;
        model_ball(0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        check_all("abort");
        repeat (3) begin
            @(negedge clk);
            chk("abort_novalid", ball_valid, 0);
        end
        ball_sw = 1'b0;
        @(negedge clk);
        bowl(3'd2);
        chk("abort_runs", runs, 2);
        chk("abort_bc", ball_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cricket_match_ctrl.md
Name: cricket_match_ctrl

Overview:
- Parametrised successor to the single-innings cricket game core.
- Runs a full two-innings limited-overs match. Each rising edge of ball_sw produces one ball outcome, taken from a configurable LFSR or from a forced test code.
- Tracks runs, wickets, overs and balls, sets the chase target, ends each innings on all-out, overs-complete or target-reached, and declares winner or tie.
- Sits between board switch inputs and the score display/LED logic.

Parameters:
- BALLS_PER_OVER, 6, legal balls per over (>=2)
- OVERS, 20, overs per innings (>=1)
- MAX_WICKETS, 10, wickets that end an innings (>=1)
- RUN_W, 10, width of run counters and target
- LFSR_W, 4, LFSR width (>=3)
- LFSR_TAPS, 4'b1100, Fibonacci feedback tap mask (XOR of masked bits shifted into LSB)
- LFSR_SEED, 4'b1001, reset value (non-zero)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- ball_sw  in  1  bowl switch; each rising edge = one delivery
- team_switch  in  1  rising edge during innings break starts innings 2
- force_en  in  1  1 = use force_code instead of LFSR
- force_code  in  3  forced outcome code
- inning_over  out  1  high while in BREAK or DONE
- game_over  out  1  high in DONE
- winner  out  1  0 = team batting first, 1 = chasing team; valid when game_over
- tie  out  1  scores level at match end
- innings  out  1  0 = first innings, 1 = second
- lfsr_out  out  LFSR_W  current LFSR state
- last_code  out  3  outcome code of most recent delivery
- ball_valid  out  1  one-cycle pulse when a delivery is scored
- runs  out  RUN_W  current innings runs
- wickets  out  clog2(MAX_WICKETS+1)  current innings wickets
- over_cnt  out  clog2(OVERS+1)  completed overs
- ball_cnt  out  clog2(BALLS_PER_OVER)  legal balls in current over
- target  out  RUN_W  first-innings runs + 1; 0 during innings 1

Behaviour:
- Reset (reset==0 at clk edge):
  - All counters, target, last_code, flags and innings cleared to 0; lfsr_out=LFSR_SEED; state INN1.
  - Edge-detect registers reset to 1, so a switch held high through reset does not count.
- LFSR:
  - Advances every clk outside reset: next = {state[LFSR_W-2:0], ^(state & LFSR_TAPS)}.
  - An all-zero state reloads LFSR_SEED.
- Delivery: ball_sw==1 and ball_sw_q==0 at a clk edge, in INN1 or INN2.
  - Code = force_en ? force_code : lfsr_out[2:0], sampled that edge.
  - All score outputs, last_code and ball_valid update at that same edge (1-cycle latency).
- Code map:
  - 0 dot
  - 1/2/3/4 = +1/+2/+3/+4 runs
  - 5 = +6
  - 6 = wicket, 0 runs
  - 7 = wide: +1 run, ball not counted (ball_cnt/over_cnt unchanged)
- Runs saturate at 2^RUN_W-1.
- Legal ball: ball_cnt increments. At BALLS_PER_OVER-1, ball_cnt wraps to 0 and over_cnt increments.
- States:
  - INN1 -> BREAK when wickets reach MAX_WICKETS or over_cnt reaches OVERS. Target=runs+1, loaded on the same edge.
  - BREAK: deliveries ignored. team_switch rising edge -> INN2; clears runs/wickets/over_cnt/ball_cnt/last_code; innings=1; target held.
  - INN2 -> DONE when runs>=target, all out, or overs complete.
    - runs>=target: winner=1.
    - runs==target-1: tie=1, winner=0.
    - Otherwise: winner=0.
  - DONE: all outputs frozen except lfsr_out, until reset.
- The terminating delivery is fully scored, and the state change happens on the same edge.
- If a wicket and overs completion coincide, the innings ends once; there is no double transition.
- team_switch is ignored outside BREAK.
- ball_sw edges during BREAK/DONE are ignored but still update ball_sw_q.
- Reset mid-match aborts immediately to reset values.

Test Plan:
All scenarios use BALLS_PER_OVER=6, OVERS=2, MAX_WICKETS=3, force_en=1 unless noted.
1. Reset: hold reset=0 3 cycles, release -> runs=0, wickets=0, target=0, inning_over=0, lfsr_out=4'b1001. Then with force_en=0, free-run 15 cycles -> LFSR visits 15 distinct non-zero states and returns to 4'b1001.
2. Scoring: codes 4,5,1,7 -> runs 4,10,11,12; ball_cnt 1,2,3,3; ball_valid one pulse each; last_code follows.
3. Overs: 12 x code 0 -> after ball 6 over_cnt=1, ball_cnt=0; after ball 12 inning_over=1, target=1. Extra ball_sw edges leave all outputs unchanged.
4. All out: codes 6,2,6,6 -> inning_over after 4th delivery, wickets=3, runs=2, target=3. team_switch edge -> innings=1, runs=0, inning_over=0, target=3.
5. Chase:
   - Innings 1 ends at 10 runs (target=11). Innings 2 codes 5,5 -> game_over=1, winner=1, tie=0, runs=12 after 2nd delivery.
   - Separate run: innings 2 ends all-out on 10 -> tie=1, winner=0.
6. Reset abort: mid innings 2, with ball_sw held high, pulse reset=0 -> all counters 0, innings=0. Releasing reset with ball_sw still high gives no ball_valid; next low-to-high edge scores.
